// File: rtl/rvga_types.sv
`default_nettype none
// =============================================================================
// Module   : rvga_types
// Brief    : Shared rvga pipeline types: opcode classes, opcodes, register index.
// Revision : 1.0 - initial release
// =============================================================================
package rvga_types;

  typedef logic [4:0] rvga_reg_idx;

  typedef enum logic [3:0] {
    OPCLASS_LUI    = 4'd0,
    OPCLASS_AUIPC  = 4'd1,
    OPCLASS_JAL    = 4'd2,
    OPCLASS_JALR   = 4'd3,
    OPCLASS_BRANCH = 4'd4,
    OPCLASS_LOAD   = 4'd5,
    OPCLASS_STORE  = 4'd6,
    OPCLASS_OPIMM  = 4'd7,
    OPCLASS_OP     = 4'd8
  } rvga_opclass;

  localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] C_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] C_OPC_OP     = 7'b0110011;

  localparam logic [31:0] RVGA_NOP = 32'h00000013;

  function automatic logic opclass_uses_rs1(input rvga_opclass op);
    return !(op inside {OPCLASS_LUI, OPCLASS_AUIPC, OPCLASS_JAL});
  endfunction

  function automatic logic opclass_uses_rs2(input rvga_opclass op);
    return op inside {OPCLASS_BRANCH, OPCLASS_STORE, OPCLASS_OP};
  endfunction

endpackage
`default_nettype wire

// File: rtl/idecode_rf.sv
`default_nettype none
// =============================================================================
// Module   : idecode_rf
// Brief    : 32x32 integer register file, 2 read / 1 write, x0 hardwired to 0.
//            RVGA_DECODE_BYPASS_EN forwards same-cycle write data to reads.
// Revision : 1.0 - initial release
// =============================================================================
module idecode_rf
  import rvga_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  rvga_reg_idx i_ra1,
  input  rvga_reg_idx i_ra2,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2,
  input  logic        i_we,
  input  rvga_reg_idx i_wa,
  input  logic [31:0] i_wd
);

  logic [31:0] r_regs [1:31];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  always_comb begin
    o_rd1 = (i_ra1 == '0) ? '0 : r_regs[i_ra1];
    o_rd2 = (i_ra2 == '0) ? '0 : r_regs[i_ra2];
`ifdef RVGA_DECODE_BYPASS_EN
    if (i_we && (i_wa != '0) && (i_wa == i_ra1)) o_rd1 = i_wd;
    if (i_we && (i_wa != '0) && (i_wa == i_ra2)) o_rd2 = i_wd;
`endif
  end

endmodule
`default_nettype wire

// File: rtl/idecode_stage.sv
`default_nettype none
// =============================================================================
// Module   : idecode_stage
// Brief    : rvga decode stage: RV32I class decode, immediates, register read,
//            load-use interlock. Option macro: RVGA_DECODE_BYPASS_EN.
// Revision : 1.0 - initial release
// =============================================================================
module idecode_stage
  import rvga_types::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] ir_i,
  input  logic        stall_v_i,
  input  logic        flush_v_i,
  output logic        stall_v_o,
  input  logic        ex_ld_v_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        wb_v_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic        v_o,
  output logic [31:0] pc_o,
  output rvga_opclass op_o,
  output logic [2:0]  funct3_o,
  output logic        funct7b5_o,
  output logic [4:0]  rd_o,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  output logic [31:0] imm_o,
  output logic        illegal_o
);

  rvga_opclass w_op;
  rvga_reg_idx w_rs1, w_rs2;
  logic [4:0]  w_rd;
  logic [31:0] w_imm, w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_rs1_data, w_rs2_data;
  logic        w_illegal, w_use_rs1, w_use_rs2;
  logic        w_ld_hazard, w_wb_hazard, w_hazard;

  assign w_rs1   = ir_i[19:15];
  assign w_rs2   = ir_i[24:20];
  assign w_imm_i = {{21{ir_i[31]}}, ir_i[30:20]};
  assign w_imm_s = {{21{ir_i[31]}}, ir_i[30:25], ir_i[11:7]};
  assign w_imm_b = {{20{ir_i[31]}}, ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
  assign w_imm_u = {ir_i[31:12], 12'b0};
  assign w_imm_j = {{12{ir_i[31]}}, ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};

  // Unknown opcodes decode as OPIMM with no destination and are flagged illegal.
  always_comb begin
    w_op      = OPCLASS_OPIMM;
    w_rd      = ir_i[11:7];
    w_imm     = w_imm_i;
    w_illegal = 1'b0;
    case (ir_i[6:0])
      C_OPC_LUI:    begin w_op = OPCLASS_LUI;    w_imm = w_imm_u; end
      C_OPC_AUIPC:  begin w_op = OPCLASS_AUIPC;  w_imm = w_imm_u; end
      C_OPC_JAL:    begin w_op = OPCLASS_JAL;    w_imm = w_imm_j; end
      C_OPC_JALR:   begin w_op = OPCLASS_JALR;   end
      C_OPC_BRANCH: begin w_op = OPCLASS_BRANCH; w_imm = w_imm_b; w_rd = '0; end
      C_OPC_LOAD:   begin w_op = OPCLASS_LOAD;   end
      C_OPC_STORE:  begin w_op = OPCLASS_STORE;  w_imm = w_imm_s; w_rd = '0; end
      C_OPC_OPIMM:  begin w_op = OPCLASS_OPIMM;  end
      C_OPC_OP:     begin w_op = OPCLASS_OP;     w_imm = '0; end
      default:      begin w_illegal = 1'b1;      w_rd = '0; end
    endcase
  end

  assign w_use_rs1 = opclass_uses_rs1(w_op);
  assign w_use_rs2 = opclass_uses_rs2(w_op);

  assign w_ld_hazard = ex_ld_v_i && (ex_rd_i != '0) &&
                       ((w_use_rs1 && (w_rs1 == ex_rd_i)) || (w_use_rs2 && (w_rs2 == ex_rd_i)));

`ifdef RVGA_DECODE_BYPASS_EN
  assign w_wb_hazard = 1'b0;
`else
  // Without forwarding, a same-cycle writeback to a used source costs one bubble.
  assign w_wb_hazard = wb_v_i && (wb_rd_i != '0) &&
                       ((w_use_rs1 && (w_rs1 == wb_rd_i)) || (w_use_rs2 && (w_rs2 == wb_rd_i)));
`endif

  assign w_hazard  = w_ld_hazard || w_wb_hazard;
  assign stall_v_o = stall_v_i || (w_hazard && !flush_v_i);

  idecode_rf u_rf (
    .clk   (clk_i),
    .rst   (rst_i),
    .i_ra1 (w_rs1),
    .i_ra2 (w_rs2),
    .o_rd1 (w_rs1_data),
    .o_rd2 (w_rs2_data),
    .i_we  (wb_v_i),
    .i_wa  (wb_rd_i),
    .i_wd  (wb_data_i)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_o        <= 1'b0;
      pc_o       <= '0;
      op_o       <= OPCLASS_LUI;
      funct3_o   <= '0;
      funct7b5_o <= 1'b0;
      rd_o       <= '0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      imm_o      <= '0;
      illegal_o  <= 1'b0;
    end else if (flush_v_i) begin
      v_o <= 1'b0;
    end else if (!stall_v_i) begin
      // An all-zero word is what fetch presents after reset: a bubble, not illegal.
      if (w_hazard || (ir_i == '0)) begin
        v_o <= 1'b0;
      end else begin
        v_o        <= 1'b1;
        pc_o       <= pc_i;
        op_o       <= w_op;
        funct3_o   <= ir_i[14:12];
        funct7b5_o <= ir_i[30];
        rd_o       <= w_rd;
        rs1_data_o <= w_rs1_data;
        rs2_data_o <= w_rs2_data;
        imm_o      <= w_imm;
        illegal_o  <= w_illegal;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_idecode_stage.sv
`default_nettype none
// =============================================================================
// Module   : tb_idecode_stage
// Brief    : Self-checking bench for idecode_stage: vector table, directed
//            corner sequences and randomized traffic against a reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_idecode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i, ir_i, wb_data_i;
  logic        stall_v_i, flush_v_i, ex_ld_v_i, wb_v_i;
  logic [4:0]  ex_rd_i, wb_rd_i;
  logic        stall_v_o, v_o, funct7b5_o, illegal_o;
  logic [31:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
  logic [3:0]  op_o;
  logic [2:0]  funct3_o;
  logic [4:0]  rd_o;

  idecode_stage dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .pc_i       (pc_i),
    .ir_i       (ir_i),
    .stall_v_i  (stall_v_i),
    .flush_v_i  (flush_v_i),
    .stall_v_o  (stall_v_o),
    .ex_ld_v_i  (ex_ld_v_i),
    .ex_rd_i    (ex_rd_i),
    .wb_v_i     (wb_v_i),
    .wb_rd_i    (wb_rd_i),
    .wb_data_i  (wb_data_i),
    .v_o        (v_o),
    .pc_o       (pc_o),
    .op_o       (op_o),
    .funct3_o   (funct3_o),
    .funct7b5_o (funct7b5_o),
    .rd_o       (rd_o),
    .rs1_data_o (rs1_data_o),
    .rs2_data_o (rs2_data_o),
    .imm_o      (imm_o),
    .illegal_o  (illegal_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Opcode per class, in op_o encoding order (LUI .. OP).
  logic [6:0] opc_tab [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

  typedef struct {
    logic [3:0]  cls;
    logic [4:0]  rd;
    logic [31:0] imm;
    bit          u1, u2, ill;
  } dec_t;

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    return 32'($signed(v << (32 - bits)) >>> (32 - bits));
  endfunction

  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    d.cls = 4'd7;
    d.ill = 1'b1;
    for (int i = 0; i < 9; i++)
      if (opc_tab[i] == ir[6:0]) begin d.cls = 4'(i); d.ill = 1'b0; end
    d.rd = (d.ill || d.cls == 4 || d.cls == 6) ? 5'd0 : ir[11:7];
    case (d.cls)
      4'd0, 4'd1: d.imm = ir & 32'hFFFF_F000;
      4'd2:       d.imm = sext(32'({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}), 21);
      4'd4:       d.imm = sext(32'({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}), 13);
      4'd6:       d.imm = sext(32'({ir[31:25], ir[11:7]}), 12);
      4'd8:       d.imm = 32'd0;
      default:    d.imm = sext(32'(ir[31:20]), 12);
    endcase
    d.u1 = !(d.cls inside {4'd0, 4'd1, 4'd2});
    d.u2 = d.cls inside {4'd4, 4'd6, 4'd8};
    return d;
  endfunction

  logic [31:0] m_rf [32];
  logic        m_v, m_f7, m_ill, m_u1, m_u2;
  logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
  logic [3:0]  m_op;
  logic [2:0]  m_f3;
  logic [4:0]  m_rd;

  task automatic model_reset();
    foreach (m_rf[i]) m_rf[i] = '0;
    m_v = 0; m_f7 = 0; m_ill = 0; m_u1 = 0; m_u2 = 0;
    m_pc = '0; m_rs1 = '0; m_rs2 = '0; m_imm = '0; m_op = '0; m_f3 = '0; m_rd = '0;
  endtask

  function automatic logic [31:0] rf_read(input logic [4:0] idx);
`ifdef RVGA_DECODE_BYPASS_EN
    if (wb_v_i && wb_rd_i != 0 && wb_rd_i == idx) return wb_data_i;
`endif
    return (idx == 0) ? 32'd0 : m_rf[idx];
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_v"}, v_o, 0);         chk({tag, "_pc"}, pc_o, 0);
    chk({tag, "_op"}, op_o, 0);       chk({tag, "_f3"}, funct3_o, 0);
    chk({tag, "_f7"}, funct7b5_o, 0); chk({tag, "_rd"}, rd_o, 0);
    chk({tag, "_rs1"}, rs1_data_o, 0); chk({tag, "_rs2"}, rs2_data_o, 0);
    chk({tag, "_imm"}, imm_o, 0);     chk({tag, "_ill"}, illegal_o, 0);
  endtask

  // Inputs already driven; checks stall, advances one edge, checks outputs.
  task automatic tick();
    dec_t d;
    bit   haz, exp_stall;
    logic [4:0] rs1, rs2;
    #1;
    d   = decode(ir_i);
    rs1 = ir_i[19:15];
    rs2 = ir_i[24:20];
    haz = ex_ld_v_i && ex_rd_i != 0 && ((d.u1 && rs1 == ex_rd_i) || (d.u2 && rs2 == ex_rd_i));
`ifndef RVGA_DECODE_BYPASS_EN
    haz = haz || (wb_v_i && wb_rd_i != 0 && ((d.u1 && rs1 == wb_rd_i) || (d.u2 && rs2 == wb_rd_i)));
`endif
    exp_stall = stall_v_i || (haz && !flush_v_i);
    chk("stall_v_o", stall_v_o, exp_stall);
    if (flush_v_i) m_v = 0;
    else if (!stall_v_i) begin
      if (haz || ir_i == 0) m_v = 0;
      else begin
        m_v = 1; m_pc = pc_i; m_op = d.cls; m_f3 = ir_i[14:12]; m_f7 = ir_i[30];
        m_rd = d.rd; m_imm = d.imm; m_ill = d.ill; m_u1 = d.u1; m_u2 = d.u2;
        m_rs1 = rf_read(rs1); m_rs2 = rf_read(rs2);
      end
    end
    if (wb_v_i && wb_rd_i != 0) m_rf[wb_rd_i] = wb_data_i;
    @(posedge clk);
    #1;
    chk("v_o", v_o, m_v);
    if (m_v) begin
      chk("pc_o", pc_o, m_pc);       chk("op_o", op_o, m_op);
      chk("funct3_o", funct3_o, m_f3); chk("funct7b5_o", funct7b5_o, m_f7);
      chk("rd_o", rd_o, m_rd);       chk("illegal_o", illegal_o, m_ill);
      if (!m_ill) chk("imm_o", imm_o, m_imm);
      if (m_u1) chk("rs1_data_o", rs1_data_o, m_rs1);
      if (m_u2) chk("rs2_data_o", rs2_data_o, m_rs2);
    end
  endtask

  task automatic idle();
    ir_i = '0; pc_i = '0; stall_v_i = 0; flush_v_i = 0;
    ex_ld_v_i = 0; ex_rd_i = '0; wb_v_i = 0; wb_rd_i = '0; wb_data_i = '0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] ir;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        f7;
    logic        ill;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h123450B7, 4'd0, 5'd1, 32'h12345000, 3'd5, 1'b0, 1'b0}; // lui
    vecs[1] = '{32'hFFFFF117, 4'd1, 5'd2, 32'hFFFFF000, 3'd7, 1'b1, 1'b0}; // auipc
    vecs[2] = '{32'hFF9FF0EF, 4'd2, 5'd1, 32'hFFFFFFF8, 3'd7, 1'b1, 1'b0}; // jal -8
    vecs[3] = '{32'h00008067, 4'd3, 5'd0, 32'h00000000, 3'd0, 1'b0, 1'b0}; // jalr
    vecs[4] = '{32'hFE000EE3, 4'd4, 5'd0, 32'hFFFFFFFC, 3'd0, 1'b1, 1'b0}; // beq -4
    vecs[5] = '{32'hFFF12183, 4'd5, 5'd3, 32'hFFFFFFFF, 3'd2, 1'b1, 1'b0}; // lw -1
    vecs[6] = '{32'h00512423, 4'd6, 5'd0, 32'h00000008, 3'd2, 1'b0, 1'b0}; // sw 8
    vecs[7] = '{32'h00528313, 4'd7, 5'd6, 32'h00000005, 3'd0, 1'b0, 1'b0}; // addi
    vecs[8] = '{32'h401283B3, 4'd8, 5'd7, 32'h00000000, 3'd0, 1'b1, 1'b0}; // sub
    vecs[9] = '{32'h00000FFF, 4'd7, 5'd0, 32'h00000000, 3'd0, 1'b0, 1'b1}; // illegal

    rst = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Post-reset zero fetch words are bubbles.
    repeat (3) tick();
    check_zero("zero_ir");

    // Writeback then dependent addi.
    wb_v_i = 1; wb_rd_i = 5'd5; wb_data_i = 32'hDEADBEEF;
    tick();
    wb_v_i = 0; ir_i = 32'h00528313; pc_i = 32'h100;
    tick();
    chk("addi_v", v_o, 1); chk("addi_op", op_o, 7); chk("addi_rd", rd_o, 6);
    chk("addi_rs1", rs1_data_o, 32'hDEADBEEF); chk("addi_imm", imm_o, 5);

    // Load-use interlock on add x7,x5,x1.
    ex_ld_v_i = 1; ex_rd_i = 5'd5; ir_i = 32'h001283B3; pc_i = 32'h104;
    #1 chk("ld_use_stall", stall_v_o, 1);
    tick();
    chk("ld_use_bubble", v_o, 0);
    ex_ld_v_i = 0;
    tick();
    chk("ld_use_issue_v", v_o, 1); chk("ld_use_issue_rd", rd_o, 7);

    // Flush beats hazard: no stall to fetch.
    ex_ld_v_i = 1; flush_v_i = 1;
    #1 chk("flush_haz_stall", stall_v_o, 0);
    tick();
    chk("flush_haz_v", v_o, 0);
    ex_ld_v_i = 0; flush_v_i = 0;

    // Same-cycle writeback and read of x5.
    wb_v_i = 1; wb_rd_i = 5'd5; wb_data_i = 32'h1234; ir_i = 32'h00528313; pc_i = 32'h108;
`ifdef RVGA_DECODE_BYPASS_EN
    #1 chk("byp_stall", stall_v_o, 0);
    tick();
    chk("byp_v", v_o, 1); chk("byp_rs1", rs1_data_o, 32'h1234);
    wb_v_i = 0;
`else
    #1 chk("nobyp_stall", stall_v_o, 1);
    tick();
    chk("nobyp_bubble", v_o, 0);
    wb_v_i = 0;
    tick();
    chk("nobyp_v", v_o, 1); chk("nobyp_rs1", rs1_data_o, 32'h1234);
`endif

    // Flushed branch, then the same branch unflushed.
    ir_i = 32'hFE000EE3; pc_i = 32'h10C; flush_v_i = 1;
    tick();
    chk("beq_flush_v", v_o, 0);
    flush_v_i = 0;
    tick();
    chk("beq_v", v_o, 1); chk("beq_imm", imm_o, 32'hFFFFFFFC); chk("beq_rd", rd_o, 0);

    // Illegal opcode, then x0 write is ignored.
    ir_i = 32'h0000007F;
    tick();
    chk("ill_v", v_o, 1); chk("ill_flag", illegal_o, 1); chk("ill_op", op_o, 7); chk("ill_rd", rd_o, 0);
    ir_i = '0; wb_v_i = 1; wb_rd_i = 5'd0; wb_data_i = 32'hFF;
    tick();
    wb_v_i = 0; ir_i = 32'h00000413;
    tick();
    chk("x0_read", rs1_data_o, 0);

    // Downstream stall holds outputs while the register file still writes.
    stall_v_i = 1; ir_i = 32'h401283B3; wb_v_i = 1; wb_rd_i = 5'd9; wb_data_i = 32'hA5A5;
    tick();
    chk("stall_hold_rd", rd_o, 8);
    stall_v_i = 0; wb_v_i = 0; ir_i = 32'h00048533;
    tick();
    chk("stall_wb_rs1", rs1_data_o, 32'hA5A5);

    // Vector table.
    for (int i = 0; i < 10; i++) begin
      ir_i = vecs[i].ir; pc_i = 32'h200 + 32'(i * 4);
      tick();
      chk("vec_v", v_o, 1);         chk("vec_op", op_o, vecs[i].op);
      chk("vec_rd", rd_o, vecs[i].rd); chk("vec_f3", funct3_o, vecs[i].f3);
      chk("vec_f7", funct7b5_o, vecs[i].f7); chk("vec_ill", illegal_o, vecs[i].ill);
      if (!vecs[i].ill) chk("vec_imm", imm_o, vecs[i].imm);
    end

    // Asynchronous reset in the middle of a load-use hazard.
    ex_ld_v_i = 1; ex_rd_i = 5'd5; ir_i = 32'h001283B3;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    chk("rst_stall_comb", stall_v_o, 1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ex_ld_v_i = 0; ir_i = '0;
    tick();
    chk("rst_first_zero", v_o, 0);
    ir_i = 32'h00528313;
    tick();
    chk("rst_capture_v", v_o, 1); chk("rst_rf_cleared", rs1_data_o, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      int k;
      logic [31:0] r;
      k = int'($urandom_range(0, 9));
      r = $urandom;
      if (k == 9) r = '0;
      else begin
        r[6:0]   = opc_tab[k];
        r[11:7]  = 5'($urandom_range(0, 7));
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
      end
      ir_i      = r;
      pc_i      = $urandom;
      ex_ld_v_i = ($urandom_range(0, 3) == 0);
      ex_rd_i   = 5'($urandom_range(0, 7));
      wb_v_i    = ($urandom_range(0, 1) == 0);
      wb_rd_i   = 5'($urandom_range(0, 7));
      wb_data_i = $urandom;
      stall_v_i = ($urandom_range(0, 6) == 0);
      flush_v_i = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/idecode_stage.md
# idecode_stage

Decode stage of the rvga five-stage pipeline, directly downstream of instruction fetch. Captures the fetched PC/instruction pair, decodes the RV32I base opcode classes, generates immediates, reads the integer register file, and registers the result for execute. Owns the architectural register file (written by writeback) and the load-use interlock that stalls fetch.

## Interface
Parameters:
- none (widths come from `rvga_types`)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; asynchronous, active-high
- pc_i  in  32  PC of the instruction from fetch
- ir_i  in  32  instruction word from fetch
- stall_v_i  in  1  downstream stall; hold all output registers
- flush_v_i  in  1  branch flush; squash the instruction being captured
- stall_v_o  out  1  stall request to fetch (combinational)
- ex_ld_v_i  in  1  instruction currently in execute is a load
- ex_rd_i  in  5  destination of that instruction
- wb_v_i  in  1  writeback valid
- wb_rd_i  in  5  writeback destination
- wb_data_i  in  32  writeback data
- v_o  out  1  output instruction valid (0 = bubble)
- pc_o  out  32  registered PC
- op_o  out  4  `rvga_opclass` (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP)
- funct3_o  out  3  ir[14:12]
- funct7b5_o  out  1  ir[30]
- rd_o  out  5  destination; 0 for BRANCH/STORE
- rs1_data_o  out  32  source 1 value
- rs2_data_o  out  32  source 2 value
- imm_o  out  32  sign-extended immediate (I/S/B/U/J by class)
- illegal_o  out  1  unrecognised opcode (v_o=1 with this set)

## Operation
- Source use: rs1 used by all classes except LUI, AUIPC, JAL; rs2 used by BRANCH, STORE, OP.
- hazard = ex_ld_v_i & ex_rd_i≠0 & ((use_rs1 & rs1==ex_rd_i) | (use_rs2 & rs2==ex_rd_i)).
- stall_v_o = stall_v_i | (hazard & ~flush_v_i).
- Register update, priority order: flush_v_i → v_o<=0; stall_v_i → hold all; hazard → v_o<=0 (bubble), fetch holds via stall_v_o; ir_i==0 → v_o<=0 (post-reset fetch content, not illegal); else capture with v_o<=1.
- Register file: 32×32, x0 reads 0, writes to x0 ignored; write on wb_v_i at clock edge.
- Immediates: I={ir[31]×21,ir[30:20]}; S={ir[31]×21,ir[30:25],ir[11:7]}; B={ir[31]×20,ir[7],ir[30:25],ir[11:8],0}; U={ir[31:12],12'b0}; J={ir[31]×12,ir[19:12],ir[20],ir[30:21],0}; OP → 0.
- Illegal: opcode[6:0] not one of the nine classes; op_o=OPIMM, rd_o=0.

## Timing
- Capture-to-output latency 1 cycle; all outputs except stall_v_o registered.
- Reset: v_o=0, pc_o=0, op_o=0, funct3_o=0, funct7b5_o=0, rd_o=0, rs1/rs2_data_o=0, imm_o=0, illegal_o=0; all 31 registers cleared to 0. stall_v_o follows its inputs combinationally.
- Reset mid-stall/hazard: state clears immediately; first post-reset edge captures only if ir_i≠0.
- Simultaneous flush and hazard: flush wins, no stall to fetch.
- Simultaneous stall_v_i and wb_v_i: register file still written; outputs held.

## Configuration
- `RVGA_DECODE_BYPASS_EN` defined: a source read matching wb_rd_i≠0 with wb_v_i in the same cycle returns wb_data_i.
- Undefined: register file returns the pre-write value; hazard additionally asserts on wb_v_i & wb_rd_i≠0 & used source==wb_rd_i, costing one bubble.

## Structure
- `rvga_types` gains: `rvga_opclass` enum, opcode constants, `RVGA_NOP` (32'h00000013), `rvga_reg_idx` (5-bit).
- One sub-module: `idecode_rf` (register file with two read ports, one write port, optional bypass). Decode and hazard logic stay in `idecode_stage`.

## Test plan
- Reset, then ir_i=0 for 3 cycles → v_o=0 throughout, all outputs 0.
- wb x5=0xDEADBEEF, then ir_i=0x00528313 (addi x6,x5,5) → next cycle v_o=1, op_o=OPIMM, rd_o=6, rs1_data_o=0xDEADBEEF, imm_o=5.
- ex_ld_v_i=1, ex_rd_i=5, ir_i=add x7,x5,x1 → stall_v_o=1, next v_o=0; drop ex_ld_v_i → instruction issues next cycle.
- Same-cycle wb x5=0x1234 and read of x5 → bypass build: rs1_data_o=0x1234, no stall; non-bypass build: one bubble then 0x1234.
- ir_i=0xFE000EE3 (beq with B-imm −4) plus flush_v_i=1 → v_o=0; repeat without flush → imm_o=0xFFFFFFFC, rd_o=0.
- ir_i=0x0000007F → v_o=1, illegal_o=1; wb to x0 of 0xFF → subsequent x0 read returns 0.
